// File: rtl/shift_register_sipo.sv
// Serial-in, parallel-out deserializer: collects WIDTH strobed bits into a
// word and presents it on a held parallel output with a one-cycle valid pulse.
module shift_register_sipo #(
  parameter int unsigned  WIDTH     = 4,
  parameter bit           MSB_FIRST = 1'b1,
  localparam int unsigned CW        = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             en_i,
  input  logic             d_i,
  input  logic             clr_i,
  output logic [WIDTH-1:0] q_o,
  output logic             valid_o,
  output logic             busy_o,
  output logic [CW-1:0]    bit_cnt_o
);

  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  // Frame position is fully captured by the bit counter; the state is a view of it.
  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_e;

  logic [WIDTH-1:0] sr_q, sr_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             valid_q, valid_d;
  logic [WIDTH-1:0] shifted;
  state_e           state_c;

  // State registers with asynchronous reset.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sr_q    <= '0;
      q_q     <= '0;
      cnt_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      sr_q    <= sr_d;
      q_q     <= q_d;
      cnt_q   <= cnt_d;
      valid_q <= valid_d;
    end
  end

  // Next-state: clr beats en; the last bit of a frame loads the output word.
  always_comb begin
    sr_d    = sr_q;
    q_d     = q_q;
    cnt_d   = cnt_q;
    valid_d = 1'b0;
    if (MSB_FIRST) begin
      shifted = {sr_q[WIDTH-2:0], d_i};
    end else begin
      shifted = {d_i, sr_q[WIDTH-1:1]};
    end
    if (clr_i) begin
      sr_d  = '0;
      cnt_d = '0;
    end else if (en_i) begin
      sr_d = shifted;
      if (cnt_q == LAST_BIT) begin
        q_d     = shifted;
        valid_d = 1'b1;
        cnt_d   = '0;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  assign state_c   = (cnt_q == '0) ? IDLE : SHIFT;
  assign busy_o    = (state_c == SHIFT);
  assign q_o       = q_q;
  assign valid_o   = valid_q;
  assign bit_cnt_o = cnt_q;

endmodule

// File: tb/tb_shift_register_sipo.sv
// Bench for the SIPO deserializer: one MSB-first and one LSB-first instance
// fed the same serial stream, checked against directed constants and a
// bit-queue reference model.
module tb_shift_register_sipo;

  localparam int unsigned W = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         en  = 1'b0;
  logic         d   = 1'b0;
  logic         clr = 1'b0;
  logic [W-1:0] q_m, q_l;
  logic         valid_m, valid_l, busy_m, busy_l;
  logic [1:0]   cnt_m, cnt_l;

  int total = 0;
  int bad   = 0;

  // Reference model: bits of the current frame in arrival order.
  bit           bits[$];
  logic [W-1:0] mq_m = '0;
  logic [W-1:0] mq_l = '0;
  logic         mvalid = 1'b0;

  always #5 clk = ~clk;

  shift_register_sipo #(.WIDTH(W), .MSB_FIRST(1'b1)) dut_m (
    .clk_i(clk), .rst_i(rst), .en_i(en), .d_i(d), .clr_i(clr),
    .q_o(q_m), .valid_o(valid_m), .busy_o(busy_m), .bit_cnt_o(cnt_m)
  );

  shift_register_sipo #(.WIDTH(W), .MSB_FIRST(1'b0)) dut_l (
    .clk_i(clk), .rst_i(rst), .en_i(en), .d_i(d), .clr_i(clr),
    .q_o(q_l), .valid_o(valid_l), .busy_o(busy_l), .bit_cnt_o(cnt_l)
  );

  // Assemble the word: bit i of the frame is weighted by its arrival order.
  function automatic logic [W-1:0] build(input bit msb);
    logic [W-1:0] w;
    w = '0;
    for (int i = 0; i < int'(W); i++) begin
      if (msb) w[W-1-i] = bits[i];
      else     w[i]     = bits[i];
    end
    return w;
  endfunction

  // Drive one cycle of inputs, advance the model, sample just after the edge.
  task automatic cyc(input logic e, input logic b, input logic c);
    @(negedge clk);
    en = e; d = b; clr = c;
    @(posedge clk);
    if (c) begin
      bits.delete();
      mvalid = 1'b0;
    end else if (e) begin
      bits.push_back(b);
      if (bits.size() == int'(W)) begin
        mq_m = build(1'b1);
        mq_l = build(1'b0);
        mvalid = 1'b1;
        bits.delete();
      end else begin
        mvalid = 1'b0;
      end
    end else begin
      mvalid = 1'b0;
    end
    #1;
  endtask

  task automatic model_reset();
    bits.delete();
    mq_m = '0;
    mq_l = '0;
    mvalid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    // Load a word plus a partial frame so the reset has something to clear.
    cyc(1, 1, 0); cyc(1, 0, 0); cyc(1, 1, 0); cyc(1, 1, 0);
    cyc(1, 1, 0); cyc(1, 1, 0);
    total++;
    if (q_m !== 4'b1011) begin bad++; $display("FAIL pre_reset_q got=%b exp=%b", q_m, 4'b1011); end
    total++;
    if (cnt_m !== 2'd2) begin bad++; $display("FAIL pre_reset_cnt got=%0d exp=2", cnt_m); end
    @(negedge clk);
    en = 1'b0;
    #2 rst = 1'b1;
    #1;
    total++;
    if ({q_m, q_l} !== 8'h00) begin bad++; $display("FAIL reset_q got=%b/%b exp=0", q_m, q_l); end
    total++;
    if ({valid_m, valid_l, busy_m, busy_l} !== 4'b0000) begin
      bad++; $display("FAIL reset_flags got=%b exp=0000", {valid_m, valid_l, busy_m, busy_l});
    end
    total++;
    if ({cnt_m, cnt_l} !== 4'b0000) begin bad++; $display("FAIL reset_cnt got=%0d/%0d exp=0", cnt_m, cnt_l); end
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  task automatic test_basic();
    logic [3:0] pat;
    logic [1:0] exp_cnt [4];
    pat = 4'b1011;
    exp_cnt = '{2'd1, 2'd2, 2'd3, 2'd0};
    for (int i = 0; i < 4; i++) begin
      cyc(1, pat[3-i], 0);
      total++;
      if (cnt_m !== exp_cnt[i]) begin bad++; $display("FAIL basic_cnt[%0d] got=%0d exp=%0d", i, cnt_m, exp_cnt[i]); end
      total++;
      if (valid_m !== (i == 3)) begin bad++; $display("FAIL basic_valid[%0d] got=%b exp=%b", i, valid_m, (i == 3)); end
    end
    total++;
    if (q_m !== 4'b1011) begin bad++; $display("FAIL basic_q_msb got=%b exp=1011", q_m); end
    total++;
    if (q_l !== 4'b1101) begin bad++; $display("FAIL basic_q_lsb got=%b exp=1101", q_l); end
    cyc(0, 0, 0);
    total++;
    if ({valid_m, busy_m} !== 2'b00) begin bad++; $display("FAIL basic_after got=%b exp=00", {valid_m, busy_m}); end
    total++;
    if (q_m !== 4'b1011) begin bad++; $display("FAIL basic_hold got=%b exp=1011", q_m); end
  endtask

  task automatic test_gapped();
    logic [3:0] pat;
    int pulses;
    pat = 4'b1011;
    pulses = 0;
    for (int i = 0; i < 4; i++) begin
      cyc(1, pat[3-i], 0);
      if (valid_m) pulses++;
      for (int g = 0; g < 3; g++) begin
        cyc(0, ~pat[3-i], 0);
        if (valid_m) pulses++;
        total++;
        if (cnt_m !== 2'((i + 1) % 4)) begin
          bad++; $display("FAIL gap_cnt[%0d.%0d] got=%0d exp=%0d", i, g, cnt_m, (i + 1) % 4);
        end
      end
    end
    total++;
    if (pulses != 1) begin bad++; $display("FAIL gap_pulses got=%0d exp=1", pulses); end
    total++;
    if (q_m !== 4'b1011) begin bad++; $display("FAIL gap_q got=%b exp=1011", q_m); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] pat;
    pat = 8'b1011_0110;
    for (int i = 0; i < 8; i++) begin
      cyc(1, pat[7-i], 0);
      total++;
      if (valid_m !== (i == 3 || i == 7)) begin
        bad++; $display("FAIL b2b_valid[%0d] got=%b exp=%b", i, valid_m, (i == 3 || i == 7));
      end
      if (i >= 3 && i < 7) begin
        total++;
        if (q_m !== 4'b1011) begin bad++; $display("FAIL b2b_q1[%0d] got=%b exp=1011", i, q_m); end
      end
    end
    total++;
    if (q_m !== 4'b0110) begin bad++; $display("FAIL b2b_q2 got=%b exp=0110", q_m); end
    total++;
    if (q_l !== 4'b0110) begin bad++; $display("FAIL b2b_q2_lsb got=%b exp=0110", q_l); end
  endtask

  task automatic test_clr();
    logic [3:0] pat;
    cyc(1, 1, 0);
    cyc(1, 1, 0);
    cyc(1, 0, 1);
    total++;
    if ({valid_m, busy_m, cnt_m} !== 4'b0000) begin
      bad++; $display("FAIL clr_state got=%b exp=0000", {valid_m, busy_m, cnt_m});
    end
    total++;
    if (q_m !== 4'b0110) begin bad++; $display("FAIL clr_q_kept got=%b exp=0110", q_m); end
    pat = 4'b0101;
    for (int i = 0; i < 4; i++) begin
      cyc(1, pat[3-i], 0);
      total++;
      if (valid_m !== (i == 3)) begin bad++; $display("FAIL clr_valid[%0d] got=%b exp=%b", i, valid_m, (i == 3)); end
    end
    total++;
    if (q_m !== 4'b0101) begin bad++; $display("FAIL clr_q got=%b exp=0101", q_m); end
    total++;
    if (q_l !== 4'b1010) begin bad++; $display("FAIL clr_q_lsb got=%b exp=1010", q_l); end
  endtask

  task automatic test_lsb_reset();
    logic [3:0] pat;
    pat = 4'b1101;
    for (int i = 0; i < 4; i++) cyc(1, pat[3-i], 0);
    total++;
    if (q_l !== 4'b1011) begin bad++; $display("FAIL lsb_q got=%b exp=1011", q_l); end
    cyc(1, 1, 0);
    cyc(1, 1, 0);
    @(negedge clk);
    en = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    #1;
    total++;
    if ({q_l, cnt_l, valid_l} !== 7'd0) begin
      bad++; $display("FAIL lsb_rst got=q%b c%0d v%b exp=0", q_l, cnt_l, valid_l);
    end
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    pat = 4'b0010;
    for (int i = 0; i < 4; i++) cyc(1, pat[3-i], 0);
    total++;
    if ({q_l, valid_l} !== {4'b0100, 1'b1}) begin
      bad++; $display("FAIL lsb_after_rst got=%b v%b exp=0100 v1", q_l, valid_l);
    end
    total++;
    if (q_m !== 4'b0010) begin bad++; $display("FAIL msb_after_rst got=%b exp=0010", q_m); end
  endtask

  task automatic test_random();
    logic prev_v;
    prev_v = 1'b0;
    for (int n = 0; n < 400; n++) begin
      cyc(($urandom_range(0, 9) < 6), 1'($urandom), ($urandom_range(0, 19) == 0));
      total++;
      if ({q_m, q_l} !== {mq_m, mq_l}) begin
        bad++; $display("FAIL rnd_q[%0d] got=%b/%b exp=%b/%b", n, q_m, q_l, mq_m, mq_l);
      end
      total++;
      if ({valid_m, valid_l} !== {mvalid, mvalid}) begin
        bad++; $display("FAIL rnd_valid[%0d] got=%b%b exp=%b", n, valid_m, valid_l, mvalid);
      end
      total++;
      if ({cnt_m, cnt_l} !== {2'(bits.size()), 2'(bits.size())}) begin
        bad++; $display("FAIL rnd_cnt[%0d] got=%0d/%0d exp=%0d", n, cnt_m, cnt_l, bits.size());
      end
      total++;
      if ({busy_m, busy_l} !== {2{bits.size() != 0}}) begin
        bad++; $display("FAIL rnd_busy[%0d] got=%b%b exp=%b", n, busy_m, busy_l, bits.size() != 0);
      end
      total++;
      if (prev_v && valid_m) begin bad++; $display("FAIL rnd_double_valid[%0d] got=1 exp=0", n); end
      prev_v = valid_m;
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_gapped();
    test_back_to_back();
    test_clr();
    test_lsb_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/shift_register_sipo.md
# shift_register_SIPO

Serial-in, parallel-out deserializer that reassembles WIDTH-bit words from a serial bit stream qualified by an enable strobe. It is the receiving end of the PISO serial link. It collects bits into an internal shift register, tracks frame position with a bit counter, and presents each completed word on a held parallel output together with a one-cycle valid pulse. It sits between the serial line (or PISO output) and any parallel consumer.

## Interface
- WIDTH, 4: word length in bits; legal range 2..32.
- MSB_FIRST, 1: 1 = first received bit lands in Q[WIDTH-1]; 0 = first received bit lands in Q[0].
- CW, $clog2(WIDTH): bit-counter width. Derived; never overridden.

- Clk  input  1  system clock; all state updates on the rising edge.
- Rst  input  1  asynchronous, active-high reset.
- en  input  1  serial bit strobe; D is sampled on a rising edge only when en=1.
- D  input  1  serial data bit.
- clr  input  1  synchronous frame restart; discards the partial word.
- Q  output  WIDTH  last completed word; held until the next word completes.
- valid  output  1  one-cycle pulse, coincident with each new Q.
- busy  output  1  high while a partial frame is held (bit_cnt != 0).
- bit_cnt  output  CW  number of bits of the current frame already received (0..WIDTH-1).

## Operation
- Internal state: shift register sr[WIDTH-1:0], counter bit_cnt, output register Q, valid flop.
- FSM, derived from bit_cnt:
  - IDLE (bit_cnt==0): en=1 -> SHIFT.
  - SHIFT (0<bit_cnt<WIDTH): en=1 on bit WIDTH -> word complete -> IDLE. clr -> IDLE.
- Priority per edge: Rst (async) > clr > en > hold.
- en=1, clr=0:
  - MSB_FIRST=1: sr <= {sr[WIDTH-2:0], D}.
  - MSB_FIRST=0: sr <= {D, sr[WIDTH-1:1]}.
  - If bit_cnt==WIDTH-1: Q <= the shifted value including D, valid <= 1, bit_cnt <= 0.
  - Otherwise bit_cnt <= bit_cnt+1 and valid <= 0.
- en=0, clr=0: sr, bit_cnt and Q hold; valid <= 0. Gaps of any length between bits are legal.
- clr=1: sr <= 0, bit_cnt <= 0, valid <= 0. Q is not modified. Any en/D in the same cycle is ignored.
- bit_cnt never reaches WIDTH, so no wrap arithmetic is needed beyond the explicit reset to 0.
- busy is combinational: (bit_cnt != 0).
- Reset values, applied asynchronously: sr=0, bit_cnt=0, Q=0, valid=0, busy=0.
- Rst asserted mid-frame discards the partial word. Reception restarts with the first en after Rst deasserts.

## Timing
- D/en setup: sampled at the rising edge of Clk; no internal synchronizer. The source must be synchronous to Clk.
- Latency: the WIDTH-th bit is sampled at edge k. Q carries the new word and valid=1 from edge k until edge k+1.
- Throughput: with en held high, one word every WIDTH cycles. valid pulses every WIDTH cycles with no dead cycle between frames.
- valid is never high for two consecutive cycles when WIDTH>=2.
- Q is stable between valid pulses, so the consumer may read it at any time after a pulse.
- clr and Rst produce no valid pulse.

## Test plan
- Reset: Rst=1 for 2 cycles, mid-clock -> Q=0, valid=0, busy=0, bit_cnt=0 immediately (asynchronous), before any edge.
- Basic MSB-first (WIDTH=4): en=1, D=1,0,1,1 on 4 edges -> bit_cnt 1,2,3,0; Q=4'b1011 and valid=1 for exactly one cycle after the 4th edge; busy low afterwards.
- Gapped strobe: the same bits with en=0 for 3 cycles between each bit -> bit_cnt holds across gaps; single valid pulse with Q=4'b1011; no valid during gaps.
- Back-to-back: continuous en, D = 1,0,1,1,0,1,1,0 -> valid pulses at edges 4 and 8; Q=4'b1011, then Q=4'b0110; Q held at 1011 in between.
- clr mid-frame: send 1,1 then clr=1 with en=1, D=0, then send 0,1,0,1 -> no valid on clr; the next valid gives Q=4'b0101. Q keeps its prior value through clr.
- LSB-first and reset mid-frame (MSB_FIRST=0): send 1,1,0,1 -> Q=4'b1011. Then send 2 bits, pulse Rst -> Q=0, bit_cnt=0, no valid; the next 4 bits 0,0,1,0 give Q=4'b0100.
